// File: rtl/rock_pkg.sv
// Shared types and default constants for the rocking-search controller.
package rock_pkg;

  localparam int W_DEF          = 3;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int MAX_FAIL_DEF   = 4;
  localparam int WD_CYC_DEF     = 1024;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_WAIT,
    ST_STEP,
    ST_HOLD,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/rock_axis_step.sv
// Saturating +/-1 stepper for one setting; blocked_o flags a move that would leave 0..2^W-1.
module rock_axis_step #(
  parameter int W = 3
) (
  input  logic [W-1:0] val_i,
  input  logic         dir_i,
  output logic [W-1:0] nxt_o,
  output logic         blocked_o
);

  always_comb begin
    blocked_o = dir_i ? (val_i == '0) : (val_i == {W{1'b1}});
    if (blocked_o)
      nxt_o = val_i;
    else if (dir_i)
      nxt_o = val_i - W'(1);
    else
      nxt_o = val_i + W'(1);
  end

endmodule

// File: rtl/rock_search_ctrl.sv
// Hill-climbing search over amplitude/frequency driven by stress-decrease samples.
// Optional WAIT-state watchdog is built when ROCK_WATCHDOG_EN is defined.
module rock_search_ctrl
  import rock_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MAX_FAIL   = MAX_FAIL_DEF,
  parameter int WD_CYC     = WD_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  logic         stress_valid,
  input  logic         stress_dec,
  output logic [W-1:0] amp,
  output logic [W-1:0] freq,
  output logic         locked,
  output logic         err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   amp_q, amp_d, freq_q, freq_d;
  logic           axis_q, axis_d, dir_q, dir_d;
  logic [FW-1:0]  fail_q, fail_d;
  logic           ever_q, ever_d, dec_q, dec_d;
  logic           locked_q, locked_d, err_q, err_d;

  // Search state after judging the latched sample, before any move.
  logic [FW-1:0]  fail_e;
  logic           ever_e, axis_e, dir_e;
  logic [W-1:0]   amp_nxt, freq_nxt;
  logic           amp_blk, freq_blk, sel_blk;

  always_comb begin
    if (dec_q) begin
      fail_e = '0;
      ever_e = 1'b1;
      axis_e = axis_q;
      dir_e  = dir_q;
    end else begin
      fail_e = fail_q + FW'(1);
      ever_e = ever_q;
      axis_e = ~axis_q;
      dir_e  = ~dir_q;
    end
  end

  rock_axis_step #(.W(W)) u_amp_step (
    .val_i(amp_q), .dir_i(dir_e), .nxt_o(amp_nxt), .blocked_o(amp_blk)
  );

  rock_axis_step #(.W(W)) u_freq_step (
    .val_i(freq_q), .dir_i(dir_e), .nxt_o(freq_nxt), .blocked_o(freq_blk)
  );

  assign sel_blk = axis_e ? freq_blk : amp_blk;

`ifdef ROCK_WATCHDOG_EN
  localparam int DW = $clog2(WD_CYC + 1);
  logic [DW-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    amp_d    = amp_q;
    freq_d   = freq_q;
    axis_d   = axis_q;
    dir_d    = dir_q;
    fail_d   = fail_q;
    ever_d   = ever_q;
    dec_d    = dec_q;
    locked_d = locked_q;
    err_d    = err_q;
`ifdef ROCK_WATCHDOG_EN
    wd_d     = '0;
`endif
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_WAIT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WAIT: begin
        if (stress_valid) begin
          dec_d   = stress_dec;
          state_d = ST_STEP;
        end
`ifdef ROCK_WATCHDOG_EN
        else if (wd_q == DW'(WD_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FAIL;
        end else begin
          wd_d = wd_q + DW'(1);
        end
`endif
      end
      ST_STEP: begin
        fail_d = fail_e;
        ever_d = ever_e;
        axis_d = axis_e;
        dir_d  = dir_e;
        if (fail_e == FW'(MAX_FAIL)) begin
          if (ever_e) begin
            locked_d = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FAIL;
          end
        end else begin
          if (axis_e) freq_d = freq_nxt;
          else        amp_d  = amp_nxt;
          // A blocked move on an improving sample is a fail not yet counted.
          if (sel_blk && dec_q) begin
            fail_d = fail_e + FW'(1);
            dir_d  = ~dir_e;
          end
          cnt_d   = CW'(SETTLE_CYC - 1);
          state_d = ST_SETTLE;
        end
      end
      default: ;
    endcase
    if (restart) begin
      state_d  = ST_SETTLE;
      cnt_d    = CW'(SETTLE_CYC - 1);
      amp_d    = '0;
      freq_d   = '0;
      axis_d   = 1'b0;
      dir_d    = 1'b0;
      fail_d   = '0;
      ever_d   = 1'b0;
      dec_d    = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
`ifdef ROCK_WATCHDOG_EN
      wd_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= CW'(SETTLE_CYC - 1);
      amp_q    <= '0;
      freq_q   <= '0;
      axis_q   <= 1'b0;
      dir_q    <= 1'b0;
      fail_q   <= '0;
      ever_q   <= 1'b0;
      dec_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef ROCK_WATCHDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      amp_q    <= amp_d;
      freq_q   <= freq_d;
      axis_q   <= axis_d;
      dir_q    <= dir_d;
      fail_q   <= fail_d;
      ever_q   <= ever_d;
      dec_q    <= dec_d;
      locked_q <= locked_d;
      err_q    <= err_d;
`ifdef ROCK_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign amp    = amp_q;
  assign freq   = freq_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule
